// File: rtl/qa_driver_sreg_rsp.sv
// Status-register read responder: fetches one status value per host request and
// posts it as a 512-bit line to the host DSM over channel 1.
//
// state   | meaning
// IDLE    | waiting for a direct strobe or a pending request
// RD_REQ  | read strobe to the status source is on the bus
// RD_WAIT | waiting for status data, or for the timeout fault value
// WR_REQ  | response line ready, held off while channel 1 is almost full
// WR_WAIT | waiting for the write response carrying our tag
module qa_driver_sreg_rsp #(
    parameter int SREG_ADDR_BITS = 32,
    parameter int DSM_RSP_LINE   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sreg_req_en,
    input  logic [SREG_ADDR_BITS-1:0] sreg_req_addr,
    input  logic [63:0]               dsm_base,
    input  logic                      dsm_base_valid,
    output logic                      sreg_rd_en,
    output logic [SREG_ADDR_BITS-1:0] sreg_rd_addr,
    input  logic                      sreg_rd_valid,
    input  logic [63:0]               sreg_rd_data,
    input  logic                      c1_almost_full,
    output logic                      c1_wr_valid,
    output logic [63:0]               c1_wr_addr,
    output logic [511:0]              c1_wr_data,
    output logic [15:0]               c1_wr_mdata,
    input  logic                      c1_wr_rsp_valid,
    input  logic [15:0]               c1_wr_rsp_mdata,
    output logic                      busy,
    output logic [15:0]               drop_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t                    state;
    logic                      pend_valid;
    logic [SREG_ADDR_BITS-1:0] pend_addr;
    logic [63:0]               data_q;
    logic                      timeout_q;
    logic [31:0]               seq;
    logic [TW-1:0]             timer;

    logic strobe_ok, take_pend, take_direct, to_pend, slot_free, drop_now;

    // A strobe that cannot start directly goes to the 1-deep pending slot; the slot
    // counts as free in the same cycle that IDLE dequeues it.
    always_comb begin
        strobe_ok   = sreg_req_en && dsm_base_valid;
        take_pend   = (state == IDLE) && pend_valid;
        take_direct = (state == IDLE) && !pend_valid && strobe_ok;
        to_pend     = strobe_ok && !take_direct;
        slot_free   = !pend_valid || take_pend;
        drop_now    = (sreg_req_en && !dsm_base_valid) || (to_pend && !slot_free);
    end

    assign busy = (state != IDLE) || pend_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            data_q       <= '0;
            timeout_q    <= 1'b0;
            seq          <= '0;
            timer        <= '0;
            drop_cnt     <= '0;
            sreg_rd_en   <= 1'b0;
            sreg_rd_addr <= '0;
            c1_wr_valid  <= 1'b0;
            c1_wr_addr   <= '0;
            c1_wr_data   <= '0;
            c1_wr_mdata  <= '0;
        end else begin
            sreg_rd_en  <= 1'b0;
            c1_wr_valid <= 1'b0;

            if (drop_now && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;

            if (to_pend && slot_free) begin
                pend_valid <= 1'b1;
                pend_addr  <= sreg_req_addr;
            end else if (take_pend) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (take_pend) begin
                        if (dsm_base_valid) begin
                            sreg_rd_addr <= pend_addr;
                            sreg_rd_en   <= 1'b1;
                            state        <= RD_REQ;
                        end
                    end else if (take_direct) begin
                        sreg_rd_addr <= sreg_req_addr;
                        sreg_rd_en   <= 1'b1;
                        state        <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    timer <= TW'(TIMEOUT_CYCLES - 1);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (sreg_rd_valid) begin
                        data_q    <= sreg_rd_data;
                        timeout_q <= 1'b0;
                        state     <= WR_REQ;
                    end else if (timer == '0) begin
                        data_q    <= 64'hDEAD_DEAD_DEAD_DEAD;
                        timeout_q <= 1'b1;
                        state     <= WR_REQ;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!c1_almost_full) begin
                        c1_wr_valid <= 1'b1;
                        c1_wr_addr  <= dsm_base + 64'(DSM_RSP_LINE);
                        c1_wr_data  <= {383'd0, timeout_q, seq + 32'd1, 32'(sreg_rd_addr), data_q};
                        c1_wr_mdata <= seq[15:0];
                        state       <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (c1_wr_rsp_valid && c1_wr_rsp_mdata == seq[15:0]) begin
                        seq   <= seq + 32'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
